// File: rtl/ex_ls.sv
// rtl/ex_ls.sv - load/store execution unit, byte-serial access on a shared 8-bit memory port
module ex_ls #(
    parameter int               TAG_W    = 4,
    parameter logic [TAG_W-1:0] UNLOCKED = {TAG_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rs_busy_in,
    input  logic [3:0]       rs_op_in,
    input  logic [31:0]      rs_offset_in,
    input  logic [TAG_W-1:0] rs_tagx_in,
    input  logic [TAG_W-1:0] rs_tagy_in,
    input  logic [TAG_W-1:0] rs_tagw_in,
    input  logic [31:0]      rs_datax_in,
    input  logic [31:0]      rs_datay_in,
    input  logic [4:0]       rs_target_in,
    output logic             busy_ls,
    output logic             en_ls,
    output logic [31:0]      ls_data,
    output logic [TAG_W-1:0] ls_tag_out,
    output logic [4:0]       ls_target_out,
    output logic             mem_req,
    input  logic             mem_gnt,
    output logic [31:0]      mem_a,
    output logic             mem_wr,
    output logic [7:0]       mem_dout,
    input  logic [7:0]       mem_din
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       op_q;
    logic [31:0]      addr_q;
    logic [31:0]      datay_q;
    logic [31:0]      result_q;
    logic [31:0]      result_nxt;
    logic [31:0]      load_val;
    logic [TAG_W-1:0] tagw_q;
    logic [4:0]       target_q;
    logic [1:0]       idx_q;
    logic [1:0]       last_idx;
    logic [1:0]       cap_idx;
    logic [7:0]       store_byte;
    logic             pend_q;
    logic             is_store;
    logic             accept;
    logic             issue;
    logic             last_issue;
    logic             capture;

    assign is_store   = op_q[3];
    assign accept     = (state == S_IDLE) && rdy && rs_busy_in && (rs_tagx_in == UNLOCKED)
                        && (!rs_op_in[3] || (rs_tagy_in == UNLOCKED));
    assign issue      = (state == S_ACCESS) && rdy && mem_gnt;
    assign last_issue = issue && (idx_q == last_idx);
    // Read data lags its grant by one cycle; pend_q remembers that a byte is in flight.
    assign capture    = rdy && pend_q;
    assign cap_idx    = idx_q - 2'd1;

    always_comb begin
        case (op_q[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    always_comb begin
        case (idx_q)
            2'd0:    store_byte = datay_q[7:0];
            2'd1:    store_byte = datay_q[15:8];
            2'd2:    store_byte = datay_q[23:16];
            default: store_byte = datay_q[31:24];
        endcase
    end

    always_comb begin
        result_nxt = result_q;
        if (capture) begin
            case (cap_idx)
                2'd0:    result_nxt[7:0]   = mem_din;
                2'd1:    result_nxt[15:8]  = mem_din;
                2'd2:    result_nxt[23:16] = mem_din;
                default: result_nxt[31:24] = mem_din;
            endcase
        end
    end

    always_comb begin
        case (op_q[2:0])
            3'b000:  load_val = {{24{result_nxt[7]}}, result_nxt[7:0]};
            3'b001:  load_val = {{16{result_nxt[15]}}, result_nxt[15:0]};
            3'b100:  load_val = {24'd0, result_nxt[7:0]};
            3'b101:  load_val = {16'd0, result_nxt[15:0]};
            default: load_val = result_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rdy) begin
            case (state)
                S_IDLE:   if (accept) state_nxt = S_ACCESS;
                S_ACCESS: if (last_issue) state_nxt = is_store ? S_DONE : S_WAIT;
                S_WAIT:   state_nxt = S_DONE;
                S_DONE:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // rst gates the port so an aborted store never lands another byte.
    always_comb begin
        busy_ls  = 1'b0;
        en_ls    = 1'b0;
        mem_req  = 1'b0;
        mem_wr   = 1'b0;
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        case (state)
            S_IDLE:   busy_ls = rs_busy_in;
            S_ACCESS: begin
                busy_ls = 1'b1;
                mem_a   = addr_q + {30'd0, idx_q};
                mem_req = rdy && !rst;
                mem_wr  = rdy && !rst && is_store;
                if (rdy && !rst && is_store) mem_dout = store_byte;
            end
            S_WAIT:   busy_ls = 1'b1;
            S_DONE:   en_ls = rdy;
            default:  busy_ls = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= 4'd0;
            addr_q        <= 32'd0;
            datay_q       <= 32'd0;
            tagw_q        <= '0;
            target_q      <= 5'd0;
            idx_q         <= 2'd0;
            result_q      <= 32'd0;
            pend_q        <= 1'b0;
            ls_data       <= 32'd0;
            ls_tag_out    <= '0;
            ls_target_out <= 5'd0;
        end else if (rdy) begin
            pend_q <= issue && !is_store;
            if (accept) begin
                op_q     <= rs_op_in;
                addr_q   <= rs_datax_in + rs_offset_in;
                datay_q  <= rs_datay_in;
                tagw_q   <= rs_tagw_in;
                target_q <= rs_target_in;
                idx_q    <= 2'd0;
                result_q <= 32'd0;
            end else begin
                if (issue) idx_q <= idx_q + 2'd1;
                result_q <= result_nxt;
            end
            if (state == S_WAIT) begin
                ls_data       <= load_val;
                ls_tag_out    <= tagw_q;
                ls_target_out <= target_q;
            end else if (last_issue && is_store) begin
                ls_data       <= 32'd0;
                ls_tag_out    <= tagw_q;
                ls_target_out <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_ex_ls.sv
// tb/tb_ex_ls.sv - self-checking bench for ex_ls against a byte-array memory model
module tb_ex_ls;
    localparam int         TAG_W = 4;
    localparam logic [3:0] UNL   = 4'hF;

    logic        clk = 1'b0;
    logic        rst, rdy, rs_busy_in, mem_gnt, busy_ls, en_ls, mem_req, mem_wr;
    logic [3:0]  rs_op_in, rs_tagx_in, rs_tagy_in, rs_tagw_in, ls_tag_out;
    logic [31:0] rs_offset_in, rs_datax_in, rs_datay_in, ls_data, mem_a;
    logic [4:0]  rs_target_in, ls_target_out;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = 8'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_ls #(.TAG_W(TAG_W), .UNLOCKED(UNL)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rs_busy_in(rs_busy_in), .rs_op_in(rs_op_in),
        .rs_offset_in(rs_offset_in), .rs_tagx_in(rs_tagx_in), .rs_tagy_in(rs_tagy_in),
        .rs_tagw_in(rs_tagw_in), .rs_datax_in(rs_datax_in), .rs_datay_in(rs_datay_in),
        .rs_target_in(rs_target_in), .busy_ls(busy_ls), .en_ls(en_ls), .ls_data(ls_data),
        .ls_tag_out(ls_tag_out), .ls_target_out(ls_target_out), .mem_req(mem_req),
        .mem_gnt(mem_gnt), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din)
    );

    // 1 KiB memory aliased over the 32-bit space; ref_mem is the bench's expected image.
    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];
    logic       pl_en = 1'b0;
    logic [9:0] pl_addr = 10'd0;
    logic [7:0] pl_data = 8'd0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_req && mem_gnt) begin
            if (mem_wr) begin
                mem[mem_a[9:0]] <= mem_dout;
                wr_cnt <= wr_cnt + 1;
            end else begin
                mem_din <= mem[mem_a[9:0]];
                rd_cnt  <= rd_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d; ref_mem[a] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    function automatic logic gnt_at(input int c, input int pct, input logic [31:0] off_mask);
        if (c < 32 && off_mask[c]) return 1'b0;
        return $urandom_range(0, 99) >= pct;
    endfunction

    // One instruction end to end; lat returns en_ls cycle relative to the accept cycle.
    task automatic run_op(input logic [3:0] op, input logic [31:0] base, input logic [31:0] off,
                          input logic [31:0] dy, input logic [3:0] tw, input logic [4:0] tg,
                          input int lockx, input int locky, input int pct,
                          input logic [31:0] off_mask, output logic [31:0] got, output int lat);
        logic [31:0] addr, v, exp_data, ak;
        int n, granted, acc_c, last_c, exp_en, lx, ly, rd0, wr0;
        bit st;
        st = op[3];
        addr = base + off;
        case (op[2:0])
            3'b000, 3'b100: n = 1;
            3'b001, 3'b101: n = 2;
            default:        n = 4;
        endcase
        v = 0;
        for (int k = 0; k < n; k++) begin
            ak = addr + 32'(k);
            v = v + ({24'd0, ref_mem[ak[9:0]]} << (8 * k));
        end
        if (st) exp_data = 0;
        else if (op[2:0] == 3'b000) exp_data = v[7] ? v - 32'h100 : v;
        else if (op[2:0] == 3'b001) exp_data = v[15] ? v - 32'h10000 : v;
        else exp_data = v;

        lx = lockx; ly = locky;
        rs_op_in = op; rs_datax_in = base; rs_offset_in = off; rs_datay_in = dy;
        rs_tagw_in = tw; rs_target_in = tg; rs_busy_in = 1'b1;
        rs_tagx_in = (lx > 0) ? 4'h2 : UNL;
        rs_tagy_in = (ly > 0) ? 4'h5 : UNL;
        mem_gnt = gnt_at(0, pct, off_mask);
        acc_c = -1; last_c = -1; lat = -1; granted = 0; got = 0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        for (int c = 0; c < 300 && lat < 0; c++) begin
            @(negedge clk);
            if (acc_c < 0) begin
                chk("idle_req", mem_req, 0);
                chk("idle_busy", busy_ls, 1);
                chk("idle_en", en_ls, 0);
                if (lx == 0 && (!st || ly == 0)) acc_c = c;
            end else if (last_c < 0) begin
                chk("acc_req", mem_req, 1);
                chk("acc_addr", mem_a, addr + 32'(granted));
                chk("acc_wr", mem_wr, st);
                chk("acc_dout", mem_dout, st ? ((dy >> (8 * granted)) & 32'hFF) : 32'h0);
                chk("acc_busy", busy_ls, 1);
                if (mem_gnt) begin
                    granted++;
                    if (granted == n) last_c = c;
                end
            end else begin
                exp_en = last_c + (st ? 1 : 2);
                if (c == exp_en) begin
                    chk("done_en", en_ls, 1);
                    chk("done_data", ls_data, exp_data);
                    chk("done_tag", ls_tag_out, tw);
                    chk("done_target", ls_target_out, st ? 5'd0 : tg);
                    chk("done_busy", busy_ls, 0);
                    got = ls_data;
                    lat = c - acc_c;
                end else begin
                    chk("tail_en", en_ls, 0);
                    chk("tail_req", mem_req, 0);
                    chk("tail_addr", mem_a, 0);
                    chk("tail_busy", busy_ls, 1);
                end
            end
            @(posedge clk); #1;
            if (lx > 0) lx--;
            if (ly > 0) ly--;
            rs_tagx_in = (lx > 0) ? 4'h2 : UNL;
            rs_tagy_in = (ly > 0) ? 4'h5 : UNL;
            mem_gnt = gnt_at(c + 1, pct, off_mask);
            if (lat >= 0) rs_busy_in = 1'b0;
        end
        checks++;
        assert (lat >= 0) else begin
            errors++;
            $error("FAIL completion_timeout observed=none expected=en_ls");
        end
        if (st) begin
            chk("store_count", 32'(wr_cnt - wr0), 32'(n));
            for (int k = 0; k < n; k++) begin
                ak = addr + 32'(k);
                ref_mem[ak[9:0]] = 8'(dy >> (8 * k));
                chk("store_byte", mem[ak[9:0]], ref_mem[ak[9:0]]);
            end
        end else begin
            chk("read_count", 32'(rd_cnt - rd0), 32'(n));
        end
    endtask

    logic [31:0] got;
    int          lat, en_cnt, wr0;
    logic [3:0]  rop;

    initial begin
        rst = 1'b1; rdy = 1'b1; rs_busy_in = 1'b0; mem_gnt = 1'b0;
        rs_op_in = 0; rs_offset_in = 0; rs_tagx_in = UNL; rs_tagy_in = UNL; rs_tagw_in = 0;
        rs_datax_in = 0; rs_datay_in = 0; rs_target_in = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 1024; i++) poke(10'(i), 8'($urandom));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_ls, 0);
        chk("rst_en", en_ls, 0);
        chk("rst_data", ls_data, 0);
        chk("rst_tag", ls_tag_out, 0);
        chk("rst_target", ls_target_out, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_a, 0);
        chk("rst_wr", mem_wr, 0);
        @(posedge clk); #1;

        // LW across base+offset, continuous grant
        poke(10'h100, 8'h78); poke(10'h101, 8'h56); poke(10'h102, 8'h34); poke(10'h103, 8'h12);
        run_op(4'b0010, 32'hFC, 32'd4, 32'h0, 4'h7, 5'd9, 0, 0, 0, 0, got, lat);
        chk("lw_value", got, 32'h12345678);
        chk("lw_latency", lat, 6);

        poke(10'h040, 8'h80);
        run_op(4'b0000, 32'h30, 32'h10, 32'h0, 4'h1, 5'd4, 0, 0, 0, 0, got, lat);
        chk("lb_value", got, 32'hFFFFFF80);
        run_op(4'b0100, 32'h40, 32'h0, 32'h0, 4'h2, 5'd5, 0, 0, 0, 0, got, lat);
        chk("lbu_value", got, 32'h00000080);
        poke(10'h050, 8'h00); poke(10'h051, 8'h80);
        run_op(4'b0001, 32'h50, 32'h0, 32'h0, 4'h3, 5'd6, 0, 0, 0, 0, got, lat);
        chk("lh_value", got, 32'hFFFF8000);

        // SH with store data locked for 3 cycles
        run_op(4'b1001, 32'h200, 32'h0, 32'hABCD, 4'h4, 5'd7, 0, 3, 0, 0, got, lat);
        chk("sh_byte0", mem[10'h200], 8'hCD);
        chk("sh_byte1", mem[10'h201], 8'hAB);
        chk("sh_latency", lat, 3);

        // LW with grant withheld for two cycles while addr+2 is pending
        poke(10'h120, 8'h11); poke(10'h121, 8'h22); poke(10'h122, 8'h33); poke(10'h123, 8'h44);
        run_op(4'b0010, 32'h120, 32'h0, 32'h0, 4'h5, 5'd8, 0, 0, 0, 32'b11000, got, lat);
        chk("stall_value", got, 32'h44332211);
        chk("stall_latency", lat, 8);

        // LW straddling the top of the address space
        run_op(4'b0010, 32'hFFFFFF00, 32'hFE, 32'h0, 4'h6, 5'd10, 0, 0, 0, 0, got, lat);
        chk("wrap_latency", lat, 6);

        // rdy low during ACCESS (cycles 2-4) and during DONE (cycles 9-11)
        poke(10'h300, 8'hA1); poke(10'h301, 8'hB2); poke(10'h302, 8'hC3); poke(10'h303, 8'hD4);
        rs_op_in = 4'b0010; rs_datax_in = 32'h300; rs_offset_in = 0; rs_tagx_in = UNL;
        rs_tagy_in = UNL; rs_tagw_in = 4'hA; rs_target_in = 5'd3; rs_busy_in = 1'b1;
        mem_gnt = 1'b1; rdy = 1'b1; en_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                chk("frz_req", mem_req, 0);
                chk("frz_addr", mem_a, 32'h301);
                chk("frz_busy", busy_ls, 1);
            end
            if (c >= 9 && c <= 11) chk("frz_done_busy", busy_ls, 0);
            chk("frz_en", en_ls, c == 12);
            if (en_ls) begin
                en_cnt++;
                chk("frz_data", ls_data, 32'hD4C3B2A1);
                chk("frz_tag", ls_tag_out, 4'hA);
            end
            @(posedge clk); #1;
            rdy = !((c + 1 >= 2 && c + 1 <= 4) || (c + 1 >= 9 && c + 1 <= 11));
            if (c == 12) rs_busy_in = 1'b0;
        end
        chk("frz_en_count", en_cnt, 1);

        // reset after two bytes of a SW
        poke(10'h3F0, 8'h00); poke(10'h3F1, 8'h00); poke(10'h3F2, 8'h00); poke(10'h3F3, 8'h00);
        rs_op_in = 4'b1010; rs_datax_in = 32'h3F0; rs_offset_in = 0; rs_datay_in = 32'h11223344;
        rs_tagw_in = 4'hB; rs_target_in = 5'd2; rs_busy_in = 1'b1; mem_gnt = 1'b1;
        wr0 = wr_cnt;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 3) begin
                chk("abort_wr", mem_wr, 0);
                chk("abort_req", mem_req, 0);
            end
            if (c >= 4) begin
                chk("abort_idle_req", mem_req, 0);
                chk("abort_idle_en", en_ls, 0);
                chk("abort_idle_busy", busy_ls, 0);
            end
            @(posedge clk); #1;
            rst = (c + 1 == 3);
            if (c + 1 >= 3) rs_busy_in = 1'b0;
        end
        chk("abort_b0", mem[10'h3F0], 8'h44);
        chk("abort_b1", mem[10'h3F1], 8'h33);
        chk("abort_b2", mem[10'h3F2], 8'h00);
        chk("abort_b3", mem[10'h3F3], 8'h00);
        chk("abort_wr_count", 32'(wr_cnt - wr0), 2);
        ref_mem[10'h3F0] = 8'h44; ref_mem[10'h3F1] = 8'h33;
        run_op(4'b0101, 32'h3F0, 32'h0, 32'h0, 4'hC, 5'd11, 0, 0, 0, 0, got, lat);
        chk("post_abort_value", got, 32'h00003344);
        chk("post_abort_latency", lat, 4);

        // randomized mix, back-to-back, with random grant stalls and tag locks
        for (int k = 0; k < 40; k++) begin
            rop = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
            run_op(rop, $urandom, $urandom, $urandom, 4'($urandom_range(0, 14)),
                   5'($urandom_range(1, 31)), $urandom_range(0, 2), $urandom_range(0, 2),
                   30, 0, got, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_ls.md
Name: ex_ls

Overview:
- Load/store execution unit: the consumer end of the load/store reservation station's dispatch interface.
- Takes the single held LS instruction, waits until its operand tags are unlocked, then computes the address.
- Performs the access byte-serially on the shared 8-bit memory port, which is arbitrated against instruction fetch.
- Broadcasts completion and load data back to the reservation stations, and drives busy_ls so the LS station knows when its slot is free.

Parameters:
TAG_W, 4, width of a register/RS tag
UNLOCKED, 4'hF, tag value meaning "operand data valid"

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; 0 freezes the block
rs_busy_in  in  1  LS station holds an instruction
rs_op_in  in  4  [3]=store, [2:0]=funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
rs_offset_in  in  32  immediate offset
rs_tagx_in  in  TAG_W  base operand tag
rs_tagy_in  in  TAG_W  store-data operand tag
rs_tagw_in  in  TAG_W  destination tag
rs_datax_in  in  32  base address operand
rs_datay_in  in  32  store data operand
rs_target_in  in  5  destination architectural register
busy_ls  out  1  LS slot still occupied
en_ls  out  1  one-cycle completion pulse
ls_data  out  32  load result (0 for stores)
ls_tag_out  out  TAG_W  tag of completing instruction
ls_target_out  out  5  destination register (0 for stores)
mem_req  out  1  request memory port
mem_gnt  in  1  port granted this cycle
mem_a  out  32  byte address
mem_wr  out  1  1=write byte, 0=read byte
mem_dout  out  8  write byte
mem_din  in  8  read byte; data for a read issued (granted) in cycle N is valid in cycle N+1

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; all registered outputs 0. Reset mid-access aborts immediately; no further mem_req or mem_wr. Reset overrides rdy.
- rdy=0: FSM, counters and latches hold. mem_req, mem_wr and en_ls are forced 0; other outputs hold. A pending completion stays in DONE until rdy returns.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: accept when rs_busy_in=1 and rs_tagx_in==UNLOCKED and (load or rs_tagy_in==UNLOCKED).
  - On accept, latch op, addr=rs_datax_in+rs_offset_in (mod 2^32, no overflow flag), datay, tagw and target.
  - Clear byte index i and the result register; go to ACCESS.
  - Tags locked: stay IDLE, no memory activity.
- Byte count n: B/BU=1, H/HU=2, W=4. funct3 values 011, 110, 111 are treated as W. Misaligned addresses are legal and handled naturally by byte access.
- ACCESS:
  - mem_req=1, mem_a=addr+i (wraps), mem_wr=store.
  - Store: mem_dout=datay[8i+7:8i]. mem_dout=0 when not writing.
  - A byte issues only in a cycle with mem_gnt=1; i then increments. With mem_gnt=0, i, mem_a and mem_dout hold, and no write takes effect.
  - Load: mem_din is captured into result byte i-1 in the cycle after each granted issue.
  - After the last byte issues: store goes to DONE, load goes to WAIT.
- WAIT (loads only): capture the final byte, go to DONE. mem_req=0.
- DONE: en_ls=1 for one cycle, ls_tag_out=tagw. Next state IDLE.
  - Loads: ls_data = result, sign-extended for B/H and zero-extended for BU/HU/W; ls_target_out=target.
  - Stores: en_ls also pulses; ls_data=0, ls_target_out=0.
- busy_ls, combinational: in IDLE it equals rs_busy_in; in ACCESS and WAIT it is 1; in DONE it is 0. The station sees its slot free in the completion cycle.
- Accept in the cycle after DONE is allowed. There is no back-to-back accept from within DONE.
- Latency with continuous grant, accept at cycle T:
  - Load of n bytes: en_ls at T+n+2.
  - Store of n bytes: en_ls at T+n+1.
- mem_a outside ACCESS is 0.

Test Plan:
- LW: datax=0xFC, offset=4, memory 0x100..0x103 = 78 56 34 12, gnt=1. Required: reads at 0x100..0x103 in T+1..T+4; en_ls at T+6 with ls_data=0x12345678 and the latched tag/target; busy_ls 0 only in that cycle.
- LB/LBU: byte 0x80 at 0x40. Required: LB gives 0xFFFFFF80; LBU gives 0x00000080. LH of bytes 00 80 at 0x50 gives 0xFFFF8000.
- SH: datay=0xABCD, address 0x200, tagy locked for 3 cycles, then UNLOCKED. Required: no mem_req while locked; then writes 0xCD at 0x200 and 0xAB at 0x201; en_ls with ls_data=0.
- LW with mem_gnt low for 2 cycles after byte 1. Required: mem_a holds at addr+2 through the stall; no duplicate or skipped byte; correct word; en_ls delayed by exactly 2 cycles.
- rdy=0 for 3 cycles during ACCESS, and again during DONE. Required: everything frozen; mem_req=0; exactly one en_ls after rdy returns.
- rst during SW after 2 bytes written. Required: next cycle IDLE; mem_wr=0; no further writes; no en_ls; accepts a fresh instruction afterwards.
